ofdm_sample_buf_ctrl: RTL and testbench

//  Master-side controller for the 1024x16 single-port block RAM (1-cycle read latency, sync reset).

---
 rtl/ofdm_pkg.sv | 22 ++
 rtl/ofdm_skid_buf.sv | 62 ++++++
 rtl/ofdm_sample_buf_ctrl.sv | 145 ++++++++++++++
 tb/tb_ofdm_sample_buf_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_pkg.sv
// Shared defaults, FSM state codes and the bit-reverse helper for the OFDM sample buffer.
package ofdm_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_ADDR_W    = 10;
  localparam int unsigned DEF_FRAME_LEN = 1024;

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  // Reverse the low nbits of a; bits above nbits are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] a, input int unsigned nbits);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < nbits && i < 32; i++) begin
      r[5'(i)] = a[5'(nbits - 1 - i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ofdm_skid_buf.sv
// Two-entry valid/ready skid FIFO; head entry is registered and drives the outputs directly.
module ofdm_skid_buf #(
  parameter int unsigned WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             head_v;
  logic             tail_v;
  logic             pop;

  assign pop       = head_v && out_ready;
  assign out_data  = head;
  assign out_valid = head_v;
  assign count     = {tail_v, head_v & ~tail_v};

  // Writer guarantees a free slot, so a push never meets a full buffer without a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      head_v <= 1'b0;
      tail_v <= 1'b0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (!head_v) begin
            head   <= in_data;
            head_v <= 1'b1;
          end else begin
            tail   <= in_data;
            tail_v <= 1'b1;
          end
        end
        2'b01: begin
          head   <= tail;
          head_v <= tail_v;
          tail_v <= 1'b0;
        end
        2'b11: begin
          if (tail_v) begin
            head <= tail;
            tail <= in_data;
          end else begin
            head <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ofdm_sample_buf_ctrl.sv
// Fills the symbol RAM from the upstream stream, then drains it in order to the FFT.
// Define BITREV_READ_EN to read the RAM in bit-reversed address order during drain.
module ofdm_sample_buf_ctrl
  import ofdm_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              ram_ce,
  output logic              ram_oce,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              frame_done
);

  localparam logic [ADDR_W-1:0] LAST_AD = ADDR_W'(FRAME_LEN - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] wr_cnt_nxt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] rd_cnt_nxt;
  logic [ADDR_W-1:0] rd_ad;
  logic              rd_pend;
  logic              rd_last_pend;
  logic              wr_go;
  logic              rd_go;
  logic              pop;
  logic              rd_space;
  logic [2:0]        occ;
  logic [1:0]        skid_cnt;
  logic [DATA_W:0]   skid_out;
  logic              skid_valid;

`ifdef BITREV_READ_EN
  localparam int unsigned LOG2_LEN = $clog2(FRAME_LEN);
  assign rd_ad = ADDR_W'(bitrev(32'(rd_cnt), LOG2_LEN));
`else
  assign rd_ad = rd_cnt;
`endif

  assign pop = m_valid && m_ready;

  // Reads still in flight already own a skid slot.
  assign occ      = 3'(skid_cnt) + 3'(rd_pend);
  assign rd_space = (occ < 3'd2) || (pop && (occ == 3'd2));

  always_comb begin
    state_nxt  = state;
    wr_cnt_nxt = wr_cnt;
    rd_cnt_nxt = rd_cnt;
    s_ready    = 1'b0;
    wr_go      = 1'b0;
    rd_go      = 1'b0;
    case (state)
      FILL: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_go      = 1'b1;
          wr_cnt_nxt = wr_cnt + 1'b1;
          if (wr_cnt == LAST_AD) begin
            state_nxt  = DRAIN;
            wr_cnt_nxt = '0;
          end
        end
      end
      DRAIN: begin
        if (rd_space) begin
          rd_go      = 1'b1;
          rd_cnt_nxt = rd_cnt + 1'b1;
          if (rd_cnt == LAST_AD) begin
            state_nxt = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (pop && m_last) begin
          state_nxt  = FILL;
          rd_cnt_nxt = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
    if (reset) begin
      s_ready = 1'b0;
      wr_go   = 1'b0;
      rd_go   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FILL;
      wr_cnt       <= '0;
      rd_cnt       <= '0;
      rd_pend      <= 1'b0;
      rd_last_pend <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_cnt       <= wr_cnt_nxt;
      rd_cnt       <= rd_cnt_nxt;
      rd_pend      <= rd_go;
      rd_last_pend <= rd_go && (rd_cnt == LAST_AD);
    end
  end

  // RAM pins follow the same-cycle handshake; idle cycles park the bus at zero.
  assign ram_oce = 1'b1;
  assign ram_ce  = wr_go || rd_go;
  assign ram_wre = wr_go;
  assign ram_ad  = wr_go ? wr_cnt : (rd_go ? rd_ad : '0);
  assign ram_din = wr_go ? s_data : '0;

  ofdm_skid_buf #(
    .WIDTH (DATA_W + 1)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .in_data   ({rd_last_pend, ram_dout}),
    .in_valid  (rd_pend),
    .out_data  (skid_out),
    .out_valid (skid_valid),
    .out_ready (m_ready),
    .count     (skid_cnt)
  );

  assign m_data     = skid_out[DATA_W-1:0];
  assign m_valid    = skid_valid;
  assign m_last     = skid_valid && skid_out[DATA_W];
  assign frame_done = pop && m_last;

endmodule

// File: tb/tb_ofdm_sample_buf_ctrl.sv
// Bench for ofdm_sample_buf_ctrl with an 8-sample symbol and a 1-cycle-latency RAM model.
module tb_ofdm_sample_buf_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned FL = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          ram_ce, ram_oce, ram_wre;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          frame_done;

  always #5 clk = ~clk;

  ofdm_sample_buf_ctrl #(.DATA_W(DW), .ADDR_W(AW), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
    .ram_din(ram_din), .ram_dout(ram_dout), .frame_done(frame_done)
  );

  logic [DW-1:0] mem [FL];
  always @(posedge clk) begin
    if (ram_ce && ram_oce) begin
      if (ram_wre) mem[ram_ad] <= ram_din;
      else         ram_dout    <= mem[ram_ad];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Output order of the symbol positions, independent of the DUT.
  function automatic int ord(input int i);
`ifdef BITREV_READ_EN
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
`else
    return i;
`endif
  endfunction

  typedef struct packed { logic last; logic [DW-1:0] d; } item_t;

  logic [DW-1:0] fr [$];
  item_t         expq [$];
  logic [DW-1:0] obs [$];
  int            obs_t [$];
  bit            accept = 1'b1;
  int            lat = -1;
  bit            prev_stall = 1'b0;
  logic [DW-1:0] pd;
  logic          pl;
  int            fd_cnt = 0;
  int            wr_idx = 0;
  int            cyc = 0;
  bit            wr_hs;
  bit            fd_exp;
  item_t         it;

  // Symbol-level model: collect a full symbol, then expect it back in read order.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      chk("reset_s_ready", 32'(s_ready), 32'd0);
      chk("reset_ram_wre", 32'(ram_wre), 32'd0);
      fr.delete();
      expq.delete();
      accept = 1'b1;
      lat = -1;
      prev_stall = 1'b0;
      wr_idx = 0;
    end else begin
      if (lat >= 0) begin
        chk($sformatf("drain_latency_c%0d", lat), 32'(m_valid), 32'(lat == 2));
        lat = (lat == 2) ? -1 : lat + 1;
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(pd));
        chk("stall_last", 32'(m_last), 32'(pl));
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_last;
      wr_hs = s_valid && accept;
      chk("s_ready", 32'(s_ready), 32'(accept));
      chk("ram_wre", 32'(ram_wre), 32'(wr_hs));
      if (wr_hs) begin
        chk("ram_ce_wr", 32'(ram_ce), 32'd1);
        chk("ram_ad_wr", 32'(ram_ad), 32'(wr_idx));
        chk("ram_din", 32'(ram_din), 32'(s_data));
      end else if (accept) begin
        chk("ram_ce_fill_idle", 32'(ram_ce), 32'd0);
      end
      fd_exp = 1'b0;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_output actual=%0h required=none", m_data);
        end else begin
          it = expq.pop_front();
          chk("m_data", 32'(m_data), 32'(it.d));
          chk("m_last", 32'(m_last), 32'(it.last));
          fd_exp = it.last;
          if (it.last) accept = 1'b1;
        end
        obs.push_back(m_data);
        obs_t.push_back(cyc);
      end
      chk("frame_done", 32'(frame_done), 32'(fd_exp));
      if (frame_done) fd_cnt++;
      if (wr_hs) begin
        fr.push_back(s_data);
        wr_idx++;
        if (fr.size() == FL) begin
          for (int i = 0; i < int'(FL); i++) begin
            expq.push_back('{last: (i == int'(FL) - 1), d: fr[ord(i)]});
          end
          fr.delete();
          accept = 1'b0;
          wr_idx = 0;
          lat = 0;
        end
      end
    end
  end

  int mmode = 0;
  int pidx = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mmode == 0) m_ready = 1'b1;
      else begin
        m_ready = ((pidx % 3) == 0);
        pidx++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      int budget;
      bit hs;
      budget = 0;
      hs = 1'b0;
      s_valid = 1'b1;
      s_data = base + DW'(i);
      while (!hs && budget < 200) begin
        @(negedge clk);
        hs = s_ready;
        step();
        budget++;
      end
      if (!hs) begin
        fail_now("write_handshake");
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (frame_done) got = 1'b1;
    end
    if (!got) fail_now("frame_done_wait");
    step();
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    s_valid = 1'b0;
    step();
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_last", 32'(m_last), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ram_ce", 32'(ram_ce), 32'd0);
    chk("rst_ram_wre", 32'(ram_wre), 32'd0);
    chk("rst_ram_ad", 32'(ram_ad), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    step();
  endtask

  // Literal expectations: frame k of obs must be base + output-order position.
  task automatic check_obs(input string tag, input logic [DW-1:0] base, input int k);
    int lit [8];
`ifdef BITREV_READ_EN
    lit = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    lit = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    if (obs.size() < (k + 1) * 8) begin
      chk($sformatf("%s_count", tag), 32'(obs.size()), 32'((k + 1) * 8));
      return;
    end
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_out%0d", tag, i), 32'(obs[k * 8 + i]), 32'(base + DW'(lit[i])));
    end
  endtask

  task automatic check_gapless(input string tag, input int k);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("%s_gap%0d", tag, i), 32'(obs_t[k * 8 + i + 1] - obs_t[k * 8 + i]), 32'd1);
    end
  endtask

  int f0;

  initial begin
    reset_dut();

    obs.delete(); obs_t.delete();
    f0 = fd_cnt;
    write_frame(16'h0010, 8);
    wait_done();
    repeat (4) step();
    chk("t1_frame_done_pulses", 32'(fd_cnt - f0), 32'd1);
    check_obs("t1", 16'h0010, 0);
    if (obs_t.size() >= 8) check_gapless("t1", 0);

    obs.delete(); obs_t.delete();
    mmode = 1;
    write_frame(16'h0010, 8);
    wait_done();
    mmode = 0;
    check_obs("t2", 16'h0010, 0);

    obs.delete(); obs_t.delete();
    write_frame(16'h0020, 8);
    f0 = fd_cnt;
    write_frame(16'h0100, 1);
    chk("t3_accept_after_done", 32'(fd_cnt - f0), 32'd1);
    write_frame(16'h0101, 7);
    wait_done();
    check_obs("t3a", 16'h0020, 0);
    check_obs("t3b", 16'h0100, 1);

    write_frame(16'h0030, 5);
    reset_dut();
    obs.delete(); obs_t.delete();
    write_frame(16'h0200, 8);
    wait_done();
    check_obs("t4", 16'h0200, 0);

    obs.delete(); obs_t.delete();
    write_frame(16'h0000, 8);
    wait_done();
    check_obs("t5", 16'h0000, 0);

    obs.delete(); obs_t.delete();
    write_frame(16'h0300, 8);
    write_frame(16'h0400, 8);
    write_frame(16'h0500, 8);
    wait_done();
    chk("t6_total_outputs", 32'(obs.size()), 32'd24);
    check_obs("t6a", 16'h0300, 0);
    check_obs("t6b", 16'h0400, 1);
    check_obs("t6c", 16'h0500, 2);
    if (obs_t.size() >= 24) begin
      check_gapless("t6a", 0);
      check_gapless("t6b", 1);
      check_gapless("t6c", 2);
    end

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
